// File: rtl/fifo_ctrl_pkg.sv
// ============================================================================
// Module      : fifo_ctrl_pkg
// Description : Shared FSM state encodings and widths for the FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_ctrl_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_if.sv
// ============================================================================
// Module      : fifo_ctrl_if
// Description : Request/strobe/status bundle between the ports and fifo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_ctrl_if #(
  parameter int PTR_L = 2
);
  import fifo_ctrl_pkg::*;

  logic               init;
  logic [PTR_L:0]     th_high;
  logic [PTR_L:0]     th_low;
  logic               push_req;
  logic               pop_req;
  logic               push;
  logic               pop;
  logic [PTR_L-1:0]   wr_ptr;
  logic [PTR_L-1:0]   rd_ptr;
  logic [PTR_L:0]     count;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic               error;
  logic [STATE_W-1:0] state;

  modport master (
    output init, th_high, th_low, push_req, pop_req,
    input  push, pop, wr_ptr, rd_ptr, count, full, empty,
           almost_full, almost_empty, error, state
  );

  modport slave (
    input  init, th_high, th_low, push_req, pop_req,
    output push, pop, wr_ptr, rd_ptr, count, full, empty,
           almost_full, almost_empty, error, state
  );
endinterface

`default_nettype wire

// File: rtl/fifo_ptr_cnt.sv
// ============================================================================
// Module      : fifo_ptr_cnt
// Description : Enable-gated wrapping pointer with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module      : fifo_ctrl
// Description : FIFO pointer/occupancy/flag controller with INIT and ERROR FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);
  localparam int CNT_W = PTR_L + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] th_high_q, th_low_q;
  logic             error_q, error_d;
  logic             push, pop, clr, err_cond, op_state;
  logic             full, empty;

  assign full  = (count_q == CNT_W'(MEM_SIZE));
  assign empty = (count_q == '0);

  always_comb begin
    op_state = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    err_cond = op_state && ((bus.push_req && full && !bus.pop_req) ||
                            (bus.pop_req && empty));
    push     = op_state && !err_cond && bus.push_req && (!full || bus.pop_req);
    pop      = op_state && !err_cond && bus.pop_req && !empty;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    error_d = error_q || err_cond;
    unique case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   if (err_cond) state_d = S_ERROR;
                else if (push) state_d = S_ACTIVE;
      S_ACTIVE: if (err_cond) state_d = S_ERROR;
                else if (count_d == '0) state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
    if (bus.init && state_q != S_RESET) begin
      state_d = S_INIT;
    end

    // Clearing on entry means INIT already shows zeroed pointers/count/error.
    clr = (state_d == S_INIT);
    if (clr) begin
      error_d = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      count_q   <= '0;
      error_q   <= 1'b0;
      th_high_q <= CNT_W'(MEM_SIZE);
      th_low_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
      if (state_q == S_INIT) begin
        th_high_q <= bus.th_high;
        th_low_q  <= bus.th_low;
      end
    end
  end

  fifo_ptr_cnt #(.W(PTR_L)) u_wr_ptr (
    .clk   (clk),
    .rst   (reset),
    .clr_i (clr),
    .en_i  (push),
    .cnt_o (bus.wr_ptr)
  );

  fifo_ptr_cnt #(.W(PTR_L)) u_rd_ptr (
    .clk   (clk),
    .rst   (reset),
    .clr_i (clr),
    .en_i  (pop),
    .cnt_o (bus.rd_ptr)
  );

  assign bus.push         = push;
  assign bus.pop          = pop;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= th_high_q);
  assign bus.almost_empty = (count_q <= th_low_q);
  assign bus.error        = error_q;
  assign bus.state        = state_q;
endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Directed self-checking bench for fifo_ctrl (MEM_SIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fifo_ctrl_if #(.PTR_L(2)) bus ();

  fifo_ctrl #(.MEM_SIZE(4), .PTR_L(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input int st, input int cnt,
                          input int wr, input int rd, input int err);
    check({tag, ".state"},  int'(bus.state),  st);
    check({tag, ".count"},  int'(bus.count),  cnt);
    check({tag, ".wr_ptr"}, int'(bus.wr_ptr), wr);
    check({tag, ".rd_ptr"}, int'(bus.rd_ptr), rd);
    check({tag, ".error"},  int'(bus.error),  err);
  endtask

  // Returns 1 ns after the rising edge, so inputs change and outputs settle well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.init = 1'b0;
    bus.th_high = '0;
    bus.th_low = '0;
    bus.push_req = 1'b0;
    bus.pop_req = 1'b0;

    #1 reset = 1'b1;
    #1;
    check_st("rst", 0, 0, 0, 0, 0);
    check("rst.empty", int'(bus.empty), 1);
    check("rst.aempty", int'(bus.almost_empty), 1);
    check("rst.full", int'(bus.full), 0);
    check("rst.afull", int'(bus.almost_full), 0);
    check("rst.push", int'(bus.push), 0);
    check("rst.pop", int'(bus.pop), 0);

    tick();
    tick();
    reset = 1'b0;
    bus.init = 1'b1;
    bus.th_high = 3'd3;
    bus.th_low = 3'd1;
    tick();
    check("init1.state", int'(bus.state), 1);
    tick();
    check("init2.state", int'(bus.state), 1);
    bus.init = 1'b0;
    tick();
    check_st("idle", 2, 0, 0, 0, 0);
    check("idle.empty", int'(bus.empty), 1);
    check("idle.aempty", int'(bus.almost_empty), 1);
    check("idle.full", int'(bus.full), 0);

    bus.push_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill.push", int'(bus.push), 1);
      check("fill.wr_pre", int'(bus.wr_ptr), i);
      tick();
      check_st("fill", 3, i + 1, (i + 1) % 4, 0, 0);
      check("fill.afull", int'(bus.almost_full), (i + 1 >= 3) ? 1 : 0);
      check("fill.aempty", int'(bus.almost_empty), (i + 1 <= 1) ? 1 : 0);
      check("fill.full", int'(bus.full), (i == 3) ? 1 : 0);
    end

    #1;
    check("ovf.push", int'(bus.push), 0);
    tick();
    check_st("ovf", 4, 4, 0, 0, 1);
    bus.push_req = 1'b0;
    bus.pop_req = 1'b1;
    #1;
    check("err.pop", int'(bus.pop), 0);
    tick();
    check_st("err.hold", 4, 4, 0, 0, 1);

    bus.pop_req = 1'b0;
    bus.init = 1'b1;
    tick();
    check_st("reinit", 1, 0, 0, 0, 0);
    bus.init = 1'b0;
    tick();
    check("reidle.state", int'(bus.state), 2);

    bus.push_req = 1'b1;
    repeat (4) tick();
    check_st("refill", 3, 4, 0, 0, 0);
    bus.pop_req = 1'b1;
    #1;
    check("both.push", int'(bus.push), 1);
    check("both.pop", int'(bus.pop), 1);
    repeat (3) tick();
    check_st("both", 3, 4, 3, 3, 0);
    check("both.full", int'(bus.full), 1);

    bus.push_req = 1'b0;
    repeat (4) tick();
    check_st("drain", 2, 0, 3, 3, 0);
    check("drain.empty", int'(bus.empty), 1);
    #1;
    check("udf.pop", int'(bus.pop), 0);
    tick();
    check_st("udf", 4, 0, 3, 3, 1);

    bus.pop_req = 1'b0;
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    tick();
    bus.push_req = 1'b1;
    tick();
    tick();
    bus.push_req = 1'b0;
    check_st("pre_arst", 3, 2, 2, 0, 0);
    #3 reset = 1'b1;
    #1;
    check_st("arst", 0, 0, 0, 0, 0);
    check("arst.empty", int'(bus.empty), 1);
    check("arst.afull", int'(bus.almost_full), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
